// File: rtl/water_mgmt_pkg.sv
// Shared types and default constants for the reservoir water-management blocks.
// Contents:
//   supply_state_t : supply health classes, ordered so a larger value is a worse class
//   *_DEF          : default thresholds and widths used as parameter defaults
//   DRAW_W         : width of the per-consumer draw requests
//   next_better()  : one-step upgrade of a supply class
package water_mgmt_pkg;

    typedef enum logic [1:0] {
        NORMAL    = 2'd0,
        CONSERVE  = 2'd1,
        RATION    = 2'd2,
        EMERGENCY = 2'd3
    } supply_state_t;

    localparam int LEVEL_W_DEF     = 10;
    localparam int POP_W_DEF       = 8;
    localparam int CONSERVE_TH_DEF = 400;
    localparam int RATION_TH_DEF   = 200;
    localparam int CRIT_TH_DEF     = 50;
    localparam int SPILL_TH_DEF    = 900;
    localparam int HYST_DEF        = 20;
    localparam int DWELL_DEF       = 4;
    localparam int ROT_PERIOD_DEF  = 8;
    localparam int DRAW_W          = 6;

    // Upgrades move exactly one class at a time.
    function automatic supply_state_t next_better(input supply_state_t s);
        supply_state_t r;
        case (s)
            CONSERVE:  r = NORMAL;
            RATION:    r = CONSERVE;
            EMERGENCY: r = RATION;
            default:   r = NORMAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/level_class_filter.sv
// Classifies a sampled reservoir level into a target supply class and
// qualifies state changes with hysteresis and a dwell counter.
// Ports:
//   clk, reset    : clock, synchronous active-high reset
//   sample_valid  : level/underflow sample valid this cycle
//   level         : sampled reservoir level
//   underflow_flag: sampled underflow flag (forces EMERGENCY, valid or not)
//   state         : current registered supply state
//   next_state    : qualified next supply state (combinational)
module level_class_filter
    import water_mgmt_pkg::*;
#(
    parameter int LEVEL_W     = LEVEL_W_DEF,
    parameter int CONSERVE_TH = CONSERVE_TH_DEF,
    parameter int RATION_TH   = RATION_TH_DEF,
    parameter int CRIT_TH     = CRIT_TH_DEF,
    parameter int HYST        = HYST_DEF,
    parameter int DWELL       = DWELL_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sample_valid,
    input  logic [LEVEL_W-1:0] level,
    input  logic               underflow_flag,
    input  supply_state_t      state,
    output supply_state_t      next_state
);

    localparam int DW = $clog2(DWELL + 1);

    // One extra bit so threshold-plus-margin sums never wrap.
    localparam logic [LEVEL_W:0] CRIT_L      = (LEVEL_W+1)'(CRIT_TH);
    localparam logic [LEVEL_W:0] RATION_L    = (LEVEL_W+1)'(RATION_TH);
    localparam logic [LEVEL_W:0] CONSERVE_L  = (LEVEL_W+1)'(CONSERVE_TH);
    localparam logic [LEVEL_W:0] UP_RATION   = (LEVEL_W+1)'(CRIT_TH + HYST);
    localparam logic [LEVEL_W:0] UP_CONSERVE = (LEVEL_W+1)'(RATION_TH + HYST);
    localparam logic [LEVEL_W:0] UP_NORMAL   = (LEVEL_W+1)'(CONSERVE_TH + HYST);

    logic [LEVEL_W:0] level_x_s;
    supply_state_t    target_s;
    supply_state_t    last_target_r;
    logic             up_qual_s;
    logic [DW-1:0]    dwell_r;
    logic [DW-1:0]    dwell_base_s;
    logic [DW-1:0]    dwell_nxt_s;

    assign level_x_s = {1'b0, level};

    // Raw target class and upgrade qualification for the current sample.
    always_comb begin
        if (level_x_s <= CRIT_L) begin
            target_s = EMERGENCY;
        end else if (level_x_s < RATION_L) begin
            target_s = RATION;
        end else if (level_x_s < CONSERVE_L) begin
            target_s = CONSERVE;
        end else begin
            target_s = NORMAL;
        end

        // Upgrade margin is measured above the lower edge of the next-better class.
        case (state)
            CONSERVE:  up_qual_s = (level_x_s >= UP_NORMAL);
            RATION:    up_qual_s = (level_x_s >= UP_CONSERVE);
            EMERGENCY: up_qual_s = (level_x_s >= UP_RATION);
            default:   up_qual_s = 1'b0;
        endcase
    end

    // Next-state qualification and dwell counting.
    always_comb begin
        next_state   = state;
        dwell_nxt_s  = dwell_r;
        // A target different from the previous sample's restarts the run.
        dwell_base_s = (target_s == last_target_r) ? dwell_r : {DW{1'b0}};

        if (underflow_flag) begin
            next_state  = EMERGENCY;
            dwell_nxt_s = {DW{1'b0}};
        end else if (!sample_valid) begin
            next_state  = state;
            dwell_nxt_s = dwell_r;
        end else if (target_s == EMERGENCY) begin
            next_state  = EMERGENCY;
            dwell_nxt_s = {DW{1'b0}};
        end else if (target_s == state) begin
            dwell_nxt_s = {DW{1'b0}};
        end else if ((target_s > state) || up_qual_s) begin
            if (dwell_base_s >= DW'(DWELL - 1)) begin
                // Downgrades jump straight to the target, upgrades take one step.
                next_state  = (target_s > state) ? target_s : next_better(state);
                dwell_nxt_s = {DW{1'b0}};
            end else begin
                dwell_nxt_s = dwell_base_s + {{(DW-1){1'b0}}, 1'b1};
            end
        end else begin
            dwell_nxt_s = {DW{1'b0}};
        end
    end

    // Dwell counter and previous-target register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_r       <= {DW{1'b0}};
            last_target_r <= NORMAL;
        end else begin
            dwell_r <= dwell_nxt_s;
            if (sample_valid) begin
                last_target_r <= target_s;
            end else begin
                last_target_r <= last_target_r;
            end
        end
    end

endmodule

// File: rtl/reservoir_ration_controller.sv
// Reservoir ration controller: samples reservoir level, flags and populations,
// tracks supply health and drives per-consumer draw requests, spill valve and alarm.
// Inputs are registered first, so a sample taken at edge N shows on the outputs
// after edge N+1.
// Ports:
//   clk, reset                  : clock, synchronous active-high reset
//   level_valid                 : level/flag/population inputs valid this cycle
//   reservoir_level             : current stored water
//   overflow, underflow         : reservoir flags
//   city_population, town_population : consumer populations
//   alarm_ack                   : alarm clear request (sticky alarm build only)
//   supply_state                : 0=NORMAL 1=CONSERVE 2=RATION 3=EMERGENCY
//   city_draw, town_draw        : per-cycle draw requests
//   spill_valve                 : open spillway
//   alarm                       : emergency alarm
// Build option: define STICKY_ALARM_EN for an alarm that latches on EMERGENCY
// entry and clears only on alarm_ack outside EMERGENCY.
module reservoir_ration_controller
    import water_mgmt_pkg::*;
#(
    parameter int LEVEL_W     = LEVEL_W_DEF,
    parameter int POP_W       = POP_W_DEF,
    parameter int CONSERVE_TH = CONSERVE_TH_DEF,
    parameter int RATION_TH   = RATION_TH_DEF,
    parameter int CRIT_TH     = CRIT_TH_DEF,
    parameter int SPILL_TH    = SPILL_TH_DEF,
    parameter int HYST        = HYST_DEF,
    parameter int DWELL       = DWELL_DEF,
    parameter int ROT_PERIOD  = ROT_PERIOD_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               level_valid,
    input  logic [LEVEL_W-1:0] reservoir_level,
    input  logic               overflow,
    input  logic               underflow,
    input  logic [POP_W-1:0]   city_population,
    input  logic [POP_W-1:0]   town_population,
    input  logic               alarm_ack,
    output logic [1:0]         supply_state,
    output logic [DRAW_W-1:0]  city_draw,
    output logic [DRAW_W-1:0]  town_draw,
    output logic               spill_valve,
    output logic               alarm
);

    localparam int RW = $clog2(ROT_PERIOD + 1);
    localparam logic [RW-1:0]      ROT_LAST  = RW'(ROT_PERIOD - 1);
    localparam logic [LEVEL_W-1:0] SPILL_SET = LEVEL_W'(SPILL_TH);
    localparam logic [LEVEL_W-1:0] SPILL_CLR = LEVEL_W'(SPILL_TH - HYST);

    logic               valid_r;
    logic [LEVEL_W-1:0] level_r;
    logic               overflow_r;
    logic               underflow_r;
    logic [POP_W-1:0]   city_pop_r;
    logic [POP_W-1:0]   town_pop_r;

    supply_state_t      state_r;
    supply_state_t      next_state_s;
    logic [RW-1:0]      rot_r;
    logic [RW-1:0]      rot_nxt_s;
    logic               serve_town_r;
    logic               serve_town_nxt_s;
    logic [DRAW_W-1:0]  city_draw_r;
    logic [DRAW_W-1:0]  town_draw_r;
    logic [DRAW_W-1:0]  city_draw_nxt_s;
    logic [DRAW_W-1:0]  town_draw_nxt_s;
    logic               spill_r;
    logic               spill_nxt_s;
    logic               alarm_r;
    logic               alarm_nxt_s;

`ifndef STICKY_ALARM_EN
    logic               unused_ack_s;
    assign unused_ack_s = alarm_ack;
`endif

    // Input sampling stage; populations only update on a valid sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r     <= 1'b0;
            level_r     <= {LEVEL_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            city_pop_r  <= {POP_W{1'b0}};
            town_pop_r  <= {POP_W{1'b0}};
        end else begin
            valid_r     <= level_valid;
            level_r     <= reservoir_level;
            overflow_r  <= overflow;
            underflow_r <= underflow;
            if (level_valid) begin
                city_pop_r <= city_population;
                town_pop_r <= town_population;
            end else begin
                city_pop_r <= city_pop_r;
                town_pop_r <= town_pop_r;
            end
        end
    end

    level_class_filter #(
        .LEVEL_W     (LEVEL_W),
        .CONSERVE_TH (CONSERVE_TH),
        .RATION_TH   (RATION_TH),
        .CRIT_TH     (CRIT_TH),
        .HYST        (HYST),
        .DWELL       (DWELL)
    ) u_filter (
        .clk            (clk),
        .reset          (reset),
        .sample_valid   (valid_r),
        .level          (level_r),
        .underflow_flag (underflow_r),
        .state          (state_r),
        .next_state     (next_state_s)
    );

    // Rotation of the served consumer while rationing; city is served first.
    always_comb begin
        rot_nxt_s        = rot_r;
        serve_town_nxt_s = serve_town_r;
        if (next_state_s != RATION) begin
            rot_nxt_s        = {RW{1'b0}};
            serve_town_nxt_s = 1'b0;
        end else if (state_r != RATION) begin
            rot_nxt_s        = {RW{1'b0}};
            serve_town_nxt_s = 1'b0;
        end else if (rot_r == ROT_LAST) begin
            rot_nxt_s        = {RW{1'b0}};
            serve_town_nxt_s = ~serve_town_r;
        end else begin
            rot_nxt_s        = rot_r + {{(RW-1){1'b0}}, 1'b1};
            serve_town_nxt_s = serve_town_r;
        end
    end

    // Draw requests follow the state the controller is moving into.
    always_comb begin
        city_draw_nxt_s = {DRAW_W{1'b0}};
        town_draw_nxt_s = {DRAW_W{1'b0}};
        case (next_state_s)
            NORMAL: begin
                city_draw_nxt_s = DRAW_W'(city_pop_r >> 3'd2);
                town_draw_nxt_s = DRAW_W'(town_pop_r >> 3'd2);
            end
            CONSERVE: begin
                city_draw_nxt_s = DRAW_W'(city_pop_r >> 3'd3);
                town_draw_nxt_s = DRAW_W'(town_pop_r >> 3'd3);
            end
            RATION: begin
                if (serve_town_nxt_s) begin
                    town_draw_nxt_s = DRAW_W'(town_pop_r >> 3'd3);
                end else begin
                    city_draw_nxt_s = DRAW_W'(city_pop_r >> 3'd3);
                end
            end
            EMERGENCY: begin
                city_draw_nxt_s = {DRAW_W{1'b0}};
                town_draw_nxt_s = {DRAW_W{1'b0}};
            end
            default: begin
                city_draw_nxt_s = {DRAW_W{1'b0}};
                town_draw_nxt_s = {DRAW_W{1'b0}};
            end
        endcase
    end

    // Spill valve with a hysteresis band; set wins over clear.
    always_comb begin
        spill_nxt_s = spill_r;
        if (valid_r) begin
            if (overflow_r || (level_r >= SPILL_SET)) begin
                spill_nxt_s = 1'b1;
            end else if (level_r < SPILL_CLR) begin
                spill_nxt_s = 1'b0;
            end else begin
                spill_nxt_s = spill_r;
            end
        end else begin
            spill_nxt_s = spill_r;
        end
    end

    // Alarm: latched with acknowledge, or a plain copy of the EMERGENCY state.
    always_comb begin
        alarm_nxt_s = alarm_r;
`ifdef STICKY_ALARM_EN
        if ((next_state_s == EMERGENCY) && (state_r != EMERGENCY)) begin
            alarm_nxt_s = 1'b1;
        end else if (alarm_ack && (state_r != EMERGENCY)) begin
            alarm_nxt_s = 1'b0;
        end else begin
            alarm_nxt_s = alarm_r;
        end
`else
        alarm_nxt_s = (next_state_s == EMERGENCY);
`endif
    end

    // State, rotation and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= NORMAL;
            rot_r        <= {RW{1'b0}};
            serve_town_r <= 1'b0;
            city_draw_r  <= {DRAW_W{1'b0}};
            town_draw_r  <= {DRAW_W{1'b0}};
            spill_r      <= 1'b0;
            alarm_r      <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            rot_r        <= rot_nxt_s;
            serve_town_r <= serve_town_nxt_s;
            city_draw_r  <= city_draw_nxt_s;
            town_draw_r  <= town_draw_nxt_s;
            spill_r      <= spill_nxt_s;
            alarm_r      <= alarm_nxt_s;
        end
    end

    assign supply_state = state_r;
    assign city_draw    = city_draw_r;
    assign town_draw    = town_draw_r;
    assign spill_valve  = spill_r;
    assign alarm        = alarm_r;

endmodule

// File: tb/tb_reservoir_ration_controller.sv
// Self-checking bench for reservoir_ration_controller: directed scenarios
// followed by randomized level/flag sequences, all compared against a
// rule-level reference model of the controller.
module tb_reservoir_ration_controller;

    localparam int CONS_TH  = 400;
    localparam int RAT_TH   = 200;
    localparam int CRIT_TH  = 50;
    localparam int SPILL_TH = 900;
    localparam int HYST     = 20;
    localparam int DWELL    = 4;
    localparam int ROT      = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       level_valid = 1'b0;
    logic [9:0] reservoir_level = 10'd0;
    logic       overflow = 1'b0;
    logic       underflow = 1'b0;
    logic [7:0] city_population = 8'd0;
    logic [7:0] town_population = 8'd0;
    logic       alarm_ack = 1'b0;
    logic [1:0] supply_state;
    logic [5:0] city_draw;
    logic [5:0] town_draw;
    logic       spill_valve;
    logic       alarm;

    always #5 clk = ~clk;

    reservoir_ration_controller dut (
        .clk             (clk),
        .reset           (reset),
        .level_valid     (level_valid),
        .reservoir_level (reservoir_level),
        .overflow        (overflow),
        .underflow       (underflow),
        .city_population (city_population),
        .town_population (town_population),
        .alarm_ack       (alarm_ack),
        .supply_state    (supply_state),
        .city_draw       (city_draw),
        .town_draw       (town_draw),
        .spill_valve     (spill_valve),
        .alarm           (alarm)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: supply class, dwell run, cycles since RATION entry.
    int m_state, m_dwell, m_last_t, m_age, m_cpop, m_tpop, m_spill, m_alarm;
    // Sample captured at the previous edge, acted on at the current one.
    bit p_valid, p_ovf, p_unf;
    int p_level, p_cp, p_tp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int target_of(input int l);
        if (l <= CRIT_TH) return 3;
        if (l < RAT_TH) return 2;
        if (l < CONS_TH) return 1;
        return 0;
    endfunction

    // Level needed to earn one step of improvement from class s.
    function automatic int up_level(input int s);
        case (s)
            1:       return CONS_TH + HYST;
            2:       return RAT_TH + HYST;
            3:       return CRIT_TH + HYST;
            default: return 1 << 30;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_dwell = 0; m_last_t = 0; m_age = 0;
        m_cpop = 0; m_tpop = 0; m_spill = 0; m_alarm = 0;
        p_valid = 1'b0; p_ovf = 1'b0; p_unf = 1'b0;
        p_level = 0; p_cp = 0; p_tp = 0;
    endtask

    task automatic model_edge();
        int old;
        int t;
        old = m_state;
`ifdef STICKY_ALARM_EN
        if (alarm_ack && old != 3) m_alarm = 0;
`endif
        if (p_unf) begin
            m_state = 3;
            m_dwell = 0;
            if (p_valid) m_last_t = target_of(p_level);
        end else if (p_valid) begin
            t = target_of(p_level);
            if (t == 3) begin
                m_state = 3;
                m_dwell = 0;
            end else if (t == m_state) begin
                m_dwell = 0;
            end else if (t > m_state || p_level >= up_level(m_state)) begin
                if (t != m_last_t) m_dwell = 0;
                m_dwell++;
                if (m_dwell == DWELL) begin
                    m_state = (t > m_state) ? t : m_state - 1;
                    m_dwell = 0;
                end
            end else begin
                m_dwell = 0;
            end
            m_last_t = t;
        end
        if (p_valid) begin
            if (p_ovf || p_level >= SPILL_TH) m_spill = 1;
            else if (p_level < SPILL_TH - HYST) m_spill = 0;
            m_cpop = p_cp;
            m_tpop = p_tp;
        end
        if (m_state == 2) m_age = (old == 2) ? m_age + 1 : 0;
`ifdef STICKY_ALARM_EN
        if (m_state == 3 && old != 3) m_alarm = 1;
`else
        m_alarm = (m_state == 3) ? 1 : 0;
`endif
        p_valid = level_valid;
        p_ovf   = overflow;
        p_unf   = underflow;
        p_level = int'(reservoir_level);
        p_cp    = int'(city_population);
        p_tp    = int'(town_population);
    endtask

    task automatic compare_all();
        int ec, et;
        bit town_turn;
        town_turn = ((m_age / ROT) % 2) == 1;
        case (m_state)
            0:       begin ec = m_cpop >> 2; et = m_tpop >> 2; end
            1:       begin ec = m_cpop >> 3; et = m_tpop >> 3; end
            2:       begin ec = town_turn ? 0 : m_cpop >> 3; et = town_turn ? m_tpop >> 3 : 0; end
            default: begin ec = 0; et = 0; end
        endcase
        chk("supply_state", 32'(supply_state), m_state);
        chk("city_draw", 32'(city_draw), ec);
        chk("town_draw", 32'(town_draw), et);
        chk("spill_valve", 32'(spill_valve), m_spill);
        chk("alarm", 32'(alarm), m_alarm);
    endtask

    task automatic step(input bit v, input int l, input bit ovf, input bit unf,
                        input int cp, input int tp, input bit ack);
        level_valid     = v;
        reservoir_level = l[9:0];
        overflow        = ovf;
        underflow       = unf;
        city_population = cp[7:0];
        town_population = tp[7:0];
        alarm_ack       = ack;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic lvl(input int l, input int n);
        for (int i = 0; i < n; i++) step(1'b1, l, 1'b0, 1'b0, 120, 60, 1'b0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        level_valid = 1'b0;
        overflow    = 1'b0;
        underflow   = 1'b0;
        alarm_ack   = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
        compare_all();
    endtask

    initial begin
        int cp, tp, l, len;

        // Reset state
        do_reset();
        chk("reset_state", 32'(supply_state), 0);
        chk("reset_city", 32'(city_draw), 0);

        // NORMAL draws
        lvl(500, 2);
        chk("t1_city", 32'(city_draw), 30);
        chk("t1_town", 32'(town_draw), 15);
        chk("t1_spill", 32'(spill_valve), 0);

        // Three low samples do not qualify; four do
        lvl(350, 3);
        lvl(500, 1);
        lvl(350, 4);
        chk("t2_hold", 32'(supply_state), 0);
        lvl(350, 1);
        chk("t2_state", 32'(supply_state), 1);
        chk("t2_city", 32'(city_draw), 15);
        chk("t2_town", 32'(town_draw), 7);

        // RATION with rotation
        lvl(150, 5);
        chk("t3_state", 32'(supply_state), 2);
        chk("t3_city", 32'(city_draw), 15);
        chk("t3_town", 32'(town_draw), 0);
        lvl(150, 7);
        chk("t3_city_last", 32'(city_draw), 15);
        lvl(150, 1);
        chk("t3_rot_city", 32'(city_draw), 0);
        chk("t3_rot_town", 32'(town_draw), 7);

        // Underflow forces EMERGENCY without dwell
        step(1'b1, 150, 1'b0, 1'b1, 120, 60, 1'b0);
        lvl(150, 1);
        chk("t4_state", 32'(supply_state), 3);
        chk("t4_city", 32'(city_draw), 0);
        chk("t4_alarm", 32'(alarm), 1);

        // Upgrade needs the margin and goes one class at a time
        lvl(60, 5);
        chk("t5_stay_emerg", 32'(supply_state), 3);
        lvl(70, 4);
        lvl(300, 1);
        chk("t5_ration", 32'(supply_state), 2);
        lvl(300, 3);
        chk("t5_one_step", 32'(supply_state), 2);
        lvl(300, 1);
        chk("t5_conserve", 32'(supply_state), 1);
`ifdef STICKY_ALARM_EN
        chk("t6_sticky_hold", 32'(alarm), 1);
        step(1'b1, 300, 1'b0, 1'b0, 120, 60, 1'b1);
        chk("t6_sticky_ack", 32'(alarm), 0);
`else
        chk("t6_alarm_off", 32'(alarm), 0);
        lvl(300, 1);
`endif

        // Spill valve hysteresis
        lvl(905, 2);
        chk("t6_spill_open", 32'(spill_valve), 1);
        lvl(890, 2);
        chk("t6_spill_band", 32'(spill_valve), 1);
        lvl(879, 2);
        chk("t6_spill_close", 32'(spill_valve), 0);

        // Reset in the middle of EMERGENCY
        step(1'b1, 500, 1'b0, 1'b1, 120, 60, 1'b0);
        lvl(500, 1);
        do_reset();
        chk("midreset_state", 32'(supply_state), 0);
        chk("midreset_alarm", 32'(alarm), 0);

        // Randomized held-level segments with flags, invalid cycles and acks
        cp = 120;
        tp = 60;
        for (int seg = 0; seg < 160; seg++) begin
            case ($urandom_range(0, 5))
                0:       l = $urandom_range(0, 60);
                1:       l = $urandom_range(40, 230);
                2:       l = $urandom_range(180, 430);
                3:       l = $urandom_range(380, 1023);
                4:       l = $urandom_range(860, 920);
                default: l = $urandom_range(0, 1023);
            endcase
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 7) == 0) begin
                cp = $urandom_range(0, 255);
                tp = $urandom_range(0, 255);
            end
            for (int k = 0; k < len; k++) begin
                step($urandom_range(0, 99) < 85, l,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 39) == 0,
                     cp, tp, $urandom_range(0, 9) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
